// File: rtl/mux_n_pipe_if.sv
// Handshake/data bundle for mux_n_pipe: N source words plus select on the input side,
// the head beat on the output side. master = upstream/downstream environment, slave = selector.
interface mux_n_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 6,
    parameter int SEL_W = 3
);
    logic [N_SRC*WIDTH-1:0] src_flat;
    logic [SEL_W-1:0]       sel;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output src_flat, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  src_flat, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_n_pipe.sv
// N-source word selector feeding a 2-entry skid buffer (head + skid), strict FIFO order.
// Optional sticky out-of-range flag sel_err when MUX_SEL_ERR_EN is defined.
//
// state | meaning
// EMPTY | no beat buffered, in_ready=1
// ONE   | head beat valid, skid empty, in_ready=1
// TWO   | head and skid valid, in_ready=0
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 6,
    parameter int SEL_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    mux_n_pipe_if.slave  bus
`ifdef MUX_SEL_ERR_EN
    ,
    output logic         sel_err
`endif
);
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [SEL_W-1:0] head_sel_q,  head_sel_d;
    logic             head_vld_q,  head_vld_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q,  skid_sel_d;
    logic             skid_vld_q,  skid_vld_d;

    logic [WIDTH-1:0] sel_word;
    logic             accept;
    logic             consume;
    logic [1:0]       state;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if ({1'b0, bus.sel} == (SEL_W+1)'(k))
                sel_word = bus.src_flat[k*WIDTH +: WIDTH];
        end
    end

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign accept  = bus.in_valid & ~skid_vld_q;
    assign consume = head_vld_q & bus.out_ready;
    assign state   = {skid_vld_q, head_vld_q};

    always_comb begin
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        head_vld_d  = head_vld_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_vld_d  = skid_vld_q;
        if (bus.flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_data_d = sel_word;
                        head_sel_d  = bus.sel;
                        head_vld_d  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head_data_d = sel_word;
                        head_sel_d  = bus.sel;
                    end else if (accept) begin
                        skid_data_d = sel_word;
                        skid_sel_d  = bus.sel;
                        skid_vld_d  = 1'b1;
                    end else if (consume) begin
                        head_vld_d  = 1'b0;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        head_data_d = skid_data_q;
                        head_sel_d  = skid_sel_q;
                        skid_vld_d  = 1'b0;
                    end
                end
                default: begin
                    head_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data_q <= '0;
            head_sel_q  <= '0;
            head_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_vld_q  <= 1'b0;
        end else begin
            head_data_q <= head_data_d;
            head_sel_q  <= head_sel_d;
            head_vld_q  <= head_vld_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_vld_q  <= skid_vld_d;
        end
    end

    assign bus.out_data  = head_data_q;
    assign bus.out_sel   = head_sel_q;
    assign bus.out_valid = head_vld_q;
    assign bus.in_ready  = ~skid_vld_q;

`ifdef MUX_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    // an out-of-range accept still counts even when flush drops the beat
    assign sel_err_d = sel_err_q | (accept & ({1'b0, bus.sel} >= (SEL_W+1)'(N_SRC)));

    always_ff @(posedge clk) begin
        if (rst) sel_err_q <= 1'b0;
        else     sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;
`endif
endmodule
